// File: rtl/vga_ctrl.sv
// vga_ctrl
// ----------------------------------------------------------------------------
// 640x480@60 display timing controller. It walks the raster with h/v counters,
// hands row/column addresses to a pixel source, then realigns the colour that
// source returns (SRC_LATENCY ticks later) with sync and blanking. RGB and the
// sync pins are registered.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_pix_en               pixel tick; every piece of state advances only on it
//   o_src_en               source advance enable (i_pix_en passed through)
//   o_addr_col/o_addr_row  source address, forced to 0 outside the active area
//   i_col_r/g/b            colour from source, SRC_LATENCY ticks after address
//   o_r/o_g/o_b            registered colour, 0 in blanking
//   o_hsync/o_vsync        registered syncs, polarity set by SYNC_POL
//   o_frame_start          high on the tick that presents (0,0)
//   o_frame_cnt            frame counter, present only when VGA_CTRL_FRAME_CNT_EN
//                          is defined
// ----------------------------------------------------------------------------
module vga_ctrl #(
  parameter int   COL_BITS    = 4,
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   SRC_LATENCY = 1,
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_pix_en,
  output logic                o_src_en,
  output logic [9:0]          o_addr_col,
  output logic [9:0]          o_addr_row,
  input  logic [COL_BITS-1:0] i_col_r,
  input  logic [COL_BITS-1:0] i_col_g,
  input  logic [COL_BITS-1:0] i_col_b,
  output logic [COL_BITS-1:0] o_r,
  output logic [COL_BITS-1:0] o_g,
  output logic [COL_BITS-1:0] o_b,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_frame_start
`ifdef VGA_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]         o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_C   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_C   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

  // Pin level when a sync pulse is not asserted.
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       active, hs_raw, vs_raw;

  logic [SRC_LATENCY-1:0] act_dly_q, act_dly_d;
  logic [SRC_LATENCY-1:0] hs_dly_q, hs_dly_d;
  logic [SRC_LATENCY-1:0] vs_dly_q, vs_dly_d;

  logic [COL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                hsync_q, hsync_d, vsync_q, vsync_d;
  logic                frame_start;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_pix_en) begin
      if (h_cnt_q == H_LAST_C) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  assign active = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign hs_raw = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
  assign vs_raw = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);

  assign o_src_en   = i_pix_en;
  assign o_addr_col = active ? h_cnt_q : '0;
  assign o_addr_row = active ? v_cnt_q : '0;

  // Gated by i_rstn so the pulse stays low while reset holds the counters at (0,0).
  assign frame_start   = i_rstn && i_pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign o_frame_start = frame_start;

  // Timing flags travel alongside the source's read pipeline so they meet the
  // returned colour on the same tick.
  always_comb begin
    act_dly_d = act_dly_q;
    hs_dly_d  = hs_dly_q;
    vs_dly_d  = vs_dly_q;
    if (i_pix_en) begin
      act_dly_d[0] = active;
      hs_dly_d[0]  = hs_raw;
      vs_dly_d[0]  = vs_raw;
      for (int i = 1; i < SRC_LATENCY; i++) begin
        act_dly_d[i] = act_dly_q[i-1];
        hs_dly_d[i]  = hs_dly_q[i-1];
        vs_dly_d[i]  = vs_dly_q[i-1];
      end
    end
  end

  always_comb begin
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (i_pix_en) begin
      r_d     = act_dly_q[SRC_LATENCY-1] ? i_col_r : '0;
      g_d     = act_dly_q[SRC_LATENCY-1] ? i_col_g : '0;
      b_d     = act_dly_q[SRC_LATENCY-1] ? i_col_b : '0;
      hsync_d = hs_dly_q[SRC_LATENCY-1] ^ SYNC_IDLE;
      vsync_d = vs_dly_q[SRC_LATENCY-1] ^ SYNC_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      act_dly_q <= '0;
      hs_dly_q  <= '0;
      vs_dly_q  <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_q   <= SYNC_IDLE;
      vsync_q   <= SYNC_IDLE;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      act_dly_q <= act_dly_d;
      hs_dly_q  <= hs_dly_d;
      vs_dly_q  <= vs_dly_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign o_r     = r_q;
  assign o_g     = g_q;
  assign o_b     = b_q;
  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;

`ifdef VGA_CTRL_FRAME_CNT_EN
  // The first frame_start after reset opens frame 0, so counting starts with
  // the second one.
  logic        first_seen_q, first_seen_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    first_seen_d = first_seen_q;
    frame_cnt_d  = frame_cnt_q;
    if (frame_start) begin
      if (first_seen_q) frame_cnt_d = frame_cnt_q + 16'd1;
      else              first_seen_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      first_seen_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      first_seen_q <= first_seen_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl. Three instances share clock, reset and pixel tick:
//   _1 : full 640x480 raster, latency 1, test-source pattern
//   _3 : full raster, latency 3, source returns constant 0xA
//   _s : shrunken raster (24x15 totals), latency 2, so whole frames are cheap
// Pins are predicted from the number of pixel ticks since reset.
module tb_vga_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pix_en = 1'b1;
  int   n;
  int   vectors = 0;
  int   miscompares = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn)
    if (!rstn) n <= 0;
    else if (pix_en) n <= n + 1;

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic [9:0] h;
    logic [9:0] v;
  } pos_t;

  function automatic pos_t decode(input int pos, input int ha, hf, hs, hb, va, vf, vs, vb);
    pos_t p;
    int ht, vt, q, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    q  = pos % (ht * vt);
    h  = q % ht;
    v  = q / ht;
    p.act = (h < ha) && (v < va);
    p.hs  = (h >= ha + hf) && (h < ha + hf + hs);
    p.vs  = (v >= va + vf) && (v < va + vf + vs);
    p.h   = 10'(h);
    p.v   = 10'(v);
    return p;
  endfunction

  // mode 0: white border on row 0 / column 0, else red ramp h/40
  // mode 1: constant 0xA on every channel
  // mode 2: {h[3:0], v[3:0], 5}
  function automatic logic [11:0] pat(input int mode, input logic [9:0] h, input logic [9:0] v);
    if (mode == 1) return 12'hAAA;
    if (mode == 2) return {h[3:0], v[3:0], 4'h5};
    if (h == 0 || v == 0) return 12'hFFF;
    return {4'(int'(h) / 40), 8'h00};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h tick=%0d t=%0t", nm, got, exp, n, $time);
    end
  endtask

  // ---------------- instance _1 ----------------
  logic       se_1, hs_1, vs_1, fs_1;
  logic [9:0] ac_1, ar_1;
  logic [3:0] r_1, g_1, b_1;
  logic [11:0] col_1;
  logic [15:0] fc_1;

  always @(posedge clk or negedge rstn)
    if (!rstn) col_1 <= '0;
    else if (pix_en) col_1 <= pat(0, ac_1, ar_1);

  vga_ctrl u_dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_pix_en(pix_en), .o_src_en(se_1),
    .o_addr_col(ac_1), .o_addr_row(ar_1),
    .i_col_r(col_1[11:8]), .i_col_g(col_1[7:4]), .i_col_b(col_1[3:0]),
    .o_r(r_1), .o_g(g_1), .o_b(b_1), .o_hsync(hs_1), .o_vsync(vs_1),
    .o_frame_start(fs_1)
`ifdef VGA_CTRL_FRAME_CNT_EN
    , .o_frame_cnt(fc_1)
`endif
  );

  // ---------------- instance _3 ----------------
  logic       se_3, hs_3, vs_3, fs_3;
  logic [9:0] ac_3, ar_3;
  logic [3:0] r_3, g_3, b_3;
  logic [15:0] fc_3;

  vga_ctrl #(.SRC_LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_pix_en(pix_en), .o_src_en(se_3),
    .o_addr_col(ac_3), .o_addr_row(ar_3),
    .i_col_r(4'hA), .i_col_g(4'hA), .i_col_b(4'hA),
    .o_r(r_3), .o_g(g_3), .o_b(b_3), .o_hsync(hs_3), .o_vsync(vs_3),
    .o_frame_start(fs_3)
`ifdef VGA_CTRL_FRAME_CNT_EN
    , .o_frame_cnt(fc_3)
`endif
  );

  // ---------------- instance _s ----------------
  logic       se_s, hs_s, vs_s, fs_s;
  logic [9:0] ac_s, ar_s;
  logic [3:0] r_s, g_s, b_s;
  logic [11:0] sp0, sp1;
  logic [15:0] fc_s;

  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      sp0 <= '0;
      sp1 <= '0;
    end else if (pix_en) begin
      sp0 <= pat(2, ac_s, ar_s);
      sp1 <= sp0;
    end

  vga_ctrl #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
             .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
             .SRC_LATENCY(2)) u_dut_s (
    .i_clk(clk), .i_rstn(rstn), .i_pix_en(pix_en), .o_src_en(se_s),
    .o_addr_col(ac_s), .o_addr_row(ar_s),
    .i_col_r(sp1[11:8]), .i_col_g(sp1[7:4]), .i_col_b(sp1[3:0]),
    .o_r(r_s), .o_g(g_s), .o_b(b_s), .o_hsync(hs_s), .o_vsync(vs_s),
    .o_frame_start(fs_s)
`ifdef VGA_CTRL_FRAME_CNT_EN
    , .o_frame_cnt(fc_s)
`endif
  );

`ifndef VGA_CTRL_FRAME_CNT_EN
  assign fc_1 = '0;
  assign fc_3 = '0;
  assign fc_s = '0;
`endif

  // Model: tick k (from 0) presents raster position k; the pins after tick k
  // show position k-L, or reset levels while the delay line is still filling.
  task automatic check_inst(input string nm, input int mode, input int lat,
                            input int ha, hf, hs, hb, va, vf, vs, vb,
                            input logic [11:0] rgb, input logic hsy, vsy, fs, se,
                            input logic [9:0] ac, ar, input logic [15:0] fc);
    pos_t c, d;
    logic [11:0] e_rgb;
    logic e_hs, e_vs;
    int frame;
    frame = (ha + hf + hs + hb) * (va + vf + vs + vb);
    c = decode(n, ha, hf, hs, hb, va, vf, vs, vb);
    if (n >= lat + 1) begin
      d = decode(n - 1 - lat, ha, hf, hs, hb, va, vf, vs, vb);
      e_rgb = d.act ? pat(mode, d.h, d.v) : 12'h000;
      e_hs  = ~d.hs;
      e_vs  = ~d.vs;
    end else begin
      e_rgb = 12'h000;
      e_hs  = 1'b1;
      e_vs  = 1'b1;
    end
    chk({nm, ".rgb"}, 32'(rgb), 32'(e_rgb));
    chk({nm, ".hsync"}, 32'(hsy), 32'(e_hs));
    chk({nm, ".vsync"}, 32'(vsy), 32'(e_vs));
    chk({nm, ".addr_col"}, 32'(ac), c.act ? 32'(c.h) : 32'd0);
    chk({nm, ".addr_row"}, 32'(ar), c.act ? 32'(c.v) : 32'd0);
    chk({nm, ".src_en"}, 32'(se), 32'(pix_en));
    chk({nm, ".frame_start"}, 32'(fs), 32'(pix_en && rstn && (n % frame == 0)));
`ifdef VGA_CTRL_FRAME_CNT_EN
    chk({nm, ".frame_cnt"}, 32'(fc), (n == 0) ? 32'd0 : 32'(((n - 1) / frame) % 65536));
`endif
  endtask

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check_inst("i1", 0, 1, 640, 16, 96, 48, 480, 10, 2, 33,
                 {r_1, g_1, b_1}, hs_1, vs_1, fs_1, se_1, ac_1, ar_1, fc_1);
      check_inst("i3", 1, 3, 640, 16, 96, 48, 480, 10, 2, 33,
                 {r_3, g_3, b_3}, hs_3, vs_3, fs_3, se_3, ac_3, ar_3, fc_3);
      check_inst("is", 2, 2, 16, 2, 4, 2, 8, 2, 2, 3,
                 {r_s, g_s, b_s}, hs_s, vs_s, fs_s, se_s, ac_s, ar_s, fc_s);
    end
  end

  // Steps to the sampling point of the cycle whose tick count equals t.
  task automatic wait_n(input int t);
    int k;
    k = 0;
    while (n != t && k < 5000) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (n != t) chk("wait_tick", 32'(n), 32'(t));
  endtask

  task automatic chk_reset_levels(input string nm);
    chk({nm, ".i1.rgb"}, 32'({r_1, g_1, b_1}), 32'h0);
    chk({nm, ".i3.rgb"}, 32'({r_3, g_3, b_3}), 32'h0);
    chk({nm, ".is.rgb"}, 32'({r_s, g_s, b_s}), 32'h0);
    chk({nm, ".syncs"}, 32'({hs_1, vs_1, hs_3, vs_3, hs_s, vs_s}), 32'h3F);
    chk({nm, ".frame_start"}, 32'({fs_1, fs_3, fs_s}), 32'h0);
`ifdef VGA_CTRL_FRAME_CNT_EN
    chk({nm, ".frame_cnt"}, 32'(fc_s), 32'h0);
`endif
  endtask

  initial begin
    int k;
    rstn = 1'b0;
    pix_en = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_levels("in_reset");
    @(negedge clk);
    rstn = 1'b1;
    #2;

    // Hand-computed pins for the free-running phase (pix_en tied high).
    wait_n(0);
    chk("i1.first_frame_start", 32'(fs_1), 32'd1);
    chk("i1.first_addr", 32'({ac_1, ar_1}), 32'd0);
    wait_n(2);    chk("i1.pix_0_0", 32'({r_1, g_1, b_1}), 32'hFFF);
    wait_n(3);    chk("i3.fill", 32'({r_3, g_3, b_3}), 32'h000);
    wait_n(4);    chk("i3.first_pix", 32'({r_3, g_3, b_3}), 32'hAAA);
    wait_n(242);  chk("is.vs_before", 32'(vs_s), 32'd1);
    wait_n(243);  chk("is.vs_first", 32'(vs_s), 32'd0);
    wait_n(290);  chk("is.vs_last", 32'(vs_s), 32'd0);
    wait_n(291);  chk("is.vs_after", 32'(vs_s), 32'd1);
    wait_n(643);  chk("i3.last_active", 32'({r_3, g_3, b_3}), 32'hAAA);
    wait_n(644);  chk("i3.first_blank", 32'({r_3, g_3, b_3}), 32'h000);
    wait_n(657);  chk("i1.hs_before", 32'(hs_1), 32'd1);
    wait_n(658);  chk("i1.hs_first", 32'(hs_1), 32'd0);
    wait_n(659);  chk("i3.hs_before", 32'(hs_3), 32'd1);
    wait_n(660);  chk("i3.hs_first", 32'(hs_3), 32'd0);
    wait_n(753);  chk("i1.hs_last", 32'(hs_1), 32'd0);
    wait_n(754);  chk("i1.hs_after", 32'(hs_1), 32'd1);
    wait_n(804);  chk("i1.pix_2_1", 32'({r_1, g_1, b_1}), 32'h000);
`ifdef VGA_CTRL_FRAME_CNT_EN
    wait_n(1080); chk("is.frame_cnt_2", 32'(fc_s), 32'd2);
    wait_n(1081); chk("is.frame_cnt_3", 32'(fc_s), 32'd3);
`endif
    wait_n(1422); chk("i1.pix_620_1", 32'({r_1, g_1, b_1}), 32'hF00);
    wait_n(1502); chk("i1.pix_700_1", 32'({r_1, g_1, b_1}), 32'h000);
    wait_n(3000);

    // One tick every four clocks.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pix_en = (c % 4 == 0);
    end

    // Reset asynchronously while the small raster is showing coloured pixels.
    k = 0;
    while (b_s == 4'h0 && k < 2000) begin
      @(negedge clk);
      pix_en = (k % 4 == 0);
      k++;
    end
    chk("is.colour_before_reset", 32'(b_s), 32'h5);
    @(negedge clk);
    pix_en = 1'b1;
    rstn = 1'b0;
    #1;
    chk_reset_levels("async_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #2;
    chk("i1.restart_frame_start", 32'(fs_1), 32'd1);
    chk("is.restart_frame_start", 32'(fs_s), 32'd1);
    wait_n(400);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
